chord_detect: RTL
=================

// Module: chord_detect
// PURPOSE
//  Receive-side counterpart of the chord-to-tone divider bank. Takes 8 square-wave
//  tone lines (one per note), measures each line's half-period, and reports which
//  notes are present as an 8-bit chord word. Used for loopback self-test of the
//  tone generator and for decoding externally supplied tones.
// PARAMETERS
//  BASE_HALF  64  half-period in clk cycles of note 0; note k expects HP_k = BASE_HALF*(k+1)
//  TOL        2   allowed |measured - HP_k| in clk cycles for a half-period to match
//  LOCK       4   consecutive matching half-periods required to assert a chord bit (1..15)
//  CW         derived: $clog2(2*BASE_HALF*8+1); per-channel counter width (11 at defaults)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous active-low reset, sampled on rising clk
//  freq       in   8  tone inputs; bit k = note k; asynchronous to clk
//  chord      out  8  detected notes; bit k = 1 while note k is locked
//  chord_chg  out  1  one-cycle pulse in the cycle after any chord bit changes
// BEHAVIOUR
//  - One clock domain (clk). rst_n is synchronous, active low: chord=0, chord_chg=0,
//    all channels IDLE, counters=0, synchronizers=0.
//  - Per channel k: 2-flop synchronizer, then edge detect (sync value != previous sync
//    value). Edge detect is 3 clk cycles after a freq transition.
//  - Counter cnt_k: cleared to 0 on edge cycle, else increments, saturating at 2*HP_k.
//    Measured half-period at an edge = cnt_k+1 (exact H-cycle toggling measures H).
//  - Match = |measured - HP_k| <= TOL; unsigned compare, no wrap.
//  - FSM per channel, match counter mc_k (4 bits):
//    IDLE   : edge -> MEAS, mc=0 (first edge is only a timing reference).
//    MEAS   : edge & match -> mc+1; if mc+1==LOCK -> LOCKED, chord[k]<=1.
//             edge & !match -> mc=0, stay MEAS.
//    LOCKED : edge & match -> stay. edge & !match -> MEAS, mc=0, chord[k]<=0.
//    any non-IDLE state: cnt_k reaches 2*HP_k with no edge -> IDLE, chord[k]<=0.
//  - Same cycle edge and timeout: edge wins (the counter clears and does not time out).
//  - chord[k] updates in the cycle after the deciding edge or timeout. chord_chg=1
//    for exactly one cycle after any bit of chord differs from its prior value.
//    Several bits changing together give one pulse.
//  - Channels are independent. All 8 may lock at once.
//  - rst_n low mid-measurement: everything returns to reset values on that edge.
//    The next lock needs LOCK+1 fresh edges.
//  - Lock latency from the first freq transition: 3 + LOCK*HP_k cycles, +1 for chord.
// CONFIGURATION
//  CHORD_DETECT_GLITCH_EN defined: extra port glitch_cnt out 8.
//    - Saturating count of mismatched half-periods on channels in MEAS or LOCKED.
//    - Several channels mismatching in one cycle add 1 per channel, saturating at 255.
//    - Reset to 0 by rst_n.
//  CHORD_DETECT_GLITCH_EN undefined: port and logic absent. All other behaviour identical.
// TESTING
//  1. rst_n=0 4 cycles, freq toggling -> chord=0, chord_chg=0 throughout; stays 0
//     for 3 cycles after release.
//  2. freq[0] toggles every 64 clk -> chord=8'h01 after the 5th detected edge
//     (~3+256 cycles); chord_chg pulses once.
//  3. freq[2] toggles every 194 clk (HP=192, err 2 <= TOL) -> chord[2]=1; same at
//     195 clk -> never sets.
//  4. freq[1] locked at 128, then held constant -> chord[1] clears 256 cycles after
//     the last edge; one chord_chg pulse.
//  5. All 8 lines at their HP_k from one start -> chord builds 01,03,07..FF over time;
//     one chord_chg per change.
//  6. freq[3] locked, then one 100-cycle half-period -> chord[3]=0 next cycle,
//     relocks after 4 good halves. With CHORD_DETECT_GLITCH_EN, glitch_cnt=1.

Source files
------------

// File: rtl/chord_detect.sv
// chord_detect: measures the half-period of eight asynchronous tone lines and
// reports which notes are present as an 8-bit chord word. Note k is expected
// to toggle every BASE_HALF*(k+1) clk cycles, within +/-TOL cycles. A note is
// reported once LOCK consecutive half-periods match.
// Optional feature: define CHORD_DETECT_GLITCH_EN to add the glitch_cnt port,
// a saturating count of mismatched half-periods seen on active channels.
module chord_detect #(
  parameter int BASE_HALF = 64,
  parameter int TOL       = 2,
  parameter int LOCK      = 4,
  parameter int CW        = $clog2(2*BASE_HALF*8+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] freq,
  output logic [7:0] chord,
  output logic       chord_chg
`ifdef CHORD_DETECT_GLITCH_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sync3;
  logic [7:0] edg;
  logic [7:0] lock_bit;
  logic [7:0] chord_prev;
`ifdef CHORD_DETECT_GLITCH_EN
  logic [7:0] mismatch;
`endif

  // Two-flop synchronizer per line plus one more stage to detect transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= freq;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edg   = sync2 ^ sync3;
  assign chord = lock_bit;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    localparam int HP = BASE_HALF * (k + 1);
    localparam logic [CW-1:0] LIM    = CW'(2 * HP);
    localparam logic [CW-1:0] LIM_M1 = CW'(2 * HP - 1);
    localparam logic [CW:0]   HP_C   = (CW+1)'(HP);
    localparam logic [CW:0]   TOL_C  = (CW+1)'(TOL);
    localparam logic [3:0]    LOCK_C = 4'(LOCK);

    logic [CW-1:0] cnt;
    logic [3:0]    mc;
    state_t        st;
    logic [CW:0]   meas;
    logic [CW:0]   diff;
    logic          match;
    logic          timeout;

    // The half-period ending at this edge is the count since the last edge plus the edge cycle itself
    assign meas    = {1'b0, cnt} + (CW+1)'(1);
    assign diff    = (meas >= HP_C) ? (meas - HP_C) : (HP_C - meas);
    assign match   = (diff <= TOL_C);
    assign timeout = (st != IDLE) && !edg[k] && (cnt == LIM_M1);
`ifdef CHORD_DETECT_GLITCH_EN
    assign mismatch[k] = edg[k] && !match && (st != IDLE);
`endif

    // Half-period counter: cleared on every edge, otherwise counts up and parks at twice the nominal half-period
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (edg[k]) begin
        cnt <= '0;
      end else if (cnt != LIM) begin
        cnt <= cnt + CW'(1);
      end
    end

    // Per-note lock FSM; an edge always takes priority over a timeout in the same cycle
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st          <= IDLE;
        mc          <= '0;
        lock_bit[k] <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (edg[k]) begin
              st <= MEAS;
              mc <= '0;
            end
          end
          MEAS: begin
            if (edg[k]) begin
              if (match) begin
                mc <= mc + 4'd1;
                if (mc + 4'd1 == LOCK_C) begin
                  st          <= LOCKED;
                  lock_bit[k] <= 1'b1;
                end
              end else begin
                mc <= '0;
              end
            end else if (timeout) begin
              st          <= IDLE;
              mc          <= '0;
              lock_bit[k] <= 1'b0;
            end
          end
          LOCKED: begin
            if (edg[k]) begin
              if (!match) begin
                st          <= MEAS;
                mc          <= '0;
                lock_bit[k] <= 1'b0;
              end
            end else if (timeout) begin
              st          <= IDLE;
              mc          <= '0;
              lock_bit[k] <= 1'b0;
            end
          end
          default: begin
            st          <= IDLE;
            mc          <= '0;
            lock_bit[k] <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-cycle change pulse, raised the cycle after the chord word takes a new value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chord_prev <= '0;
      chord_chg  <= 1'b0;
    end else begin
      chord_prev <= chord;
      chord_chg  <= (chord != chord_prev);
    end
  end

`ifdef CHORD_DETECT_GLITCH_EN
  logic [3:0] nmis;
  logic [8:0] gsum;

  // Number of channels reporting a bad half-period this cycle, and the unsaturated running total
  always_comb begin
    nmis = 4'd0;
    for (int i = 0; i < 8; i++) begin
      nmis = nmis + {3'b000, mismatch[i]};
    end
    gsum = {1'b0, glitch_cnt} + {5'b00000, nmis};
  end

  // Glitch counter sticks at 255 rather than wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (gsum > 9'd255) begin
      glitch_cnt <= 8'd255;
    end else begin
      glitch_cnt <= gsum[7:0];
    end
  end
`endif

endmodule
